// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the board PLL (iCE40 SB_PLL40 family) from the raw oscillator
// clock. It holds RESETB low for a fixed time and then waits, with a timeout,
// for LOCK. LOCK must then stay high for a qualification window. Only after
// that window is the downstream design released from reset. If lock is lost,
// the sequence starts again. Failed attempts are retried a bounded number of
// times before a fault is latched.
//
// Optional feature (macro PLL_SEQ_STATUS_EN):
//   When defined, the block gets two extra outputs. retry_count mirrors the
//   retry counter. lock_loss_count is a saturating count of RUN exits that
//   were caused by lock loss.
//
// Ports:
//   clock            in   oscillator clock (pre-PLL)
//   reset            in   synchronous, active-high
//   pll_lock         in   PLL LOCK output, asynchronous to clock
//   relock_req       in   single-cycle pulse, forces a new attempt from RUN/FAULT
//   pll_resetb       out  to PLL RESETB, 0 = PLL held in reset
//   sys_reset        out  active-high reset for the PLL-clocked design
//   ready            out  1 only in RUN
//   fault            out  1 only in FAULT
//   state_dbg        out  current FSM state (debug/observation)
//   retry_count      out  [PLL_SEQ_STATUS_EN] current retry count
//   lock_loss_count  out  [PLL_SEQ_STATUS_EN] saturating lock-loss count
//
// Handshake note: relock_req is a plain level-sampled pulse with no ready
// return. It is acted on only in RUN or FAULT. In every other state it is
// dropped without being stored.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state_dbg
`ifdef PLL_SEQ_STATUS_EN
  ,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
`endif
);

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic             lock_meta, lock_s;

  // Two-flop synchronizer for the asynchronous LOCK pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state logic. cnt is cleared on every state change, so it only ever
  // counts within one state and cannot wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retries_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            state_d   = ST_PLLRST;
            retries_d = retries_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A glitch in lock sends us back to WAIT with a fresh timeout. This
        // does not count as a failed attempt.
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s || relock_req) begin
          state_d = ST_PLLRST;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_d   = ST_PLLRST;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      default: begin
        state_d   = ST_PLLRST;
        cnt_d     = '0;
        retries_d = '0;
      end
    endcase
  end

  // State register. The outputs are decoded from the next state so that they
  // change on the same edge as the state itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_PLLRST;
      cnt_q      <= '0;
      retries_q  <= '0;
      pll_resetb <= 1'b0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      pll_resetb <= (state_d == ST_WAIT) || (state_d == ST_STABLE) ||
                    (state_d == ST_RUN);
      sys_reset  <= (state_d != ST_RUN);
      ready      <= (state_d == ST_RUN);
      fault      <= (state_d == ST_FAULT);
    end
  end

  assign state_dbg = state_q;

`ifdef PLL_SEQ_STATUS_EN
  // Only exits from RUN caused by lock loss are counted. An exit caused by
  // relock_req alone is not. When both happen together, the exit counts.
  logic loss_event;
  assign loss_event  = (state_q == ST_RUN) && !lock_s;
  assign retry_count = retries_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_loss_count <= '0;
    end else if (loss_event && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Bench for pll_lock_sequencer, using the small bring-up parameters. A
// behavioural model moves between bring-up phases. Each phase has an elapsed
// count, and the synchronizer is modelled as a two-entry history queue of the
// raw lock pin. Every cycle the DUT outputs are compared with the model.
// Directed sequences check the documented cycle timings. A randomized
// section then runs after them. Define PLL_SEQ_STATUS_EN to also check the
// status outputs.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int RESET_CYCLES  = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 16;

  // Model phases (bench-local names, independent of the DUT encoding).
  localparam int P_RST    = 10;
  localparam int P_WAIT   = 11;
  localparam int P_STABLE = 12;
  localparam int P_RUN    = 13;
  localparam int P_FAULT  = 14;

  logic       clock;
  logic       reset;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [2:0] state_dbg;
`ifdef PLL_SEQ_STATUS_EN
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int   m_phase   = P_RST;
  int   m_elapsed = 0;
  int   m_tries   = 0;
  int   m_losses  = 0;
  int   m_streak  = 0;
  logic m_hist[$];
  logic prev_ready = 1'b0;

  pll_lock_sequencer #(
    .RESET_CYCLES (RESET_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_W        (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pll_lock       (pll_lock),
    .relock_req     (relock_req),
    .pll_resetb     (pll_resetb),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .fault          (fault),
    .state_dbg      (state_dbg)
`ifdef PLL_SEQ_STATUS_EN
    ,
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
`endif
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_enter(input int phase);
    m_phase   = phase;
    m_elapsed = 0;
  endtask

  // Applies one clock edge of the bring-up rules to the model.
  task automatic model_edge();
    logic ls;
    ls = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(pll_lock);
    if (reset) begin
      model_enter(P_RST);
      m_tries  = 0;
      m_losses = 0;
      m_streak = 0;
      m_hist   = '{1'b0, 1'b0};
      return;
    end
    m_streak = ls ? m_streak + 1 : 0;
    case (m_phase)
      P_RST:
        if (m_elapsed + 1 == RESET_CYCLES) model_enter(P_WAIT);
        else m_elapsed++;
      P_WAIT:
        if (ls) model_enter(P_STABLE);
        else if (m_elapsed + 1 == LOCK_TIMEOUT) begin
          if (m_tries == MAX_RETRIES) model_enter(P_FAULT);
          else begin
            m_tries++;
            model_enter(P_RST);
          end
        end else m_elapsed++;
      P_STABLE:
        if (!ls) model_enter(P_WAIT);
        else if (m_elapsed + 1 == STABLE_CYCLES) begin
          m_tries = 0;
          model_enter(P_RUN);
        end else m_elapsed++;
      P_RUN:
        if (!ls || relock_req) begin
          if (!ls && m_losses < 255) m_losses++;
          model_enter(P_RST);
        end
      P_FAULT:
        if (relock_req) begin
          m_tries = 0;
          model_enter(P_RST);
        end
      default: model_enter(P_RST);
    endcase
  endtask

  task automatic compare_all();
    check("pll_resetb", pll_resetb,
          (m_phase == P_WAIT || m_phase == P_STABLE || m_phase == P_RUN));
    check("sys_reset", sys_reset, (m_phase != P_RUN));
    check("ready", ready, (m_phase == P_RUN));
    check("fault", fault, (m_phase == P_FAULT));
    check("state_legal", (state_dbg <= 3'd4), 1);
    // Release must be preceded by a full window of synchronized lock.
    if (ready && !prev_ready) check("lock_streak", (m_streak >= STABLE_CYCLES), 1);
    prev_ready = ready;
`ifdef PLL_SEQ_STATUS_EN
    check("retry_count", retry_count, m_tries);
    check("lock_loss_count", lock_loss_count, m_losses);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One edge. Inputs are stable across the posedge, and outputs are
  // sampled on the negedge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  // The last reset edge is cycle 0 of the following measurement.
  task automatic apply_reset();
    reset      = 1'b1;
    relock_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
  endtask

  // Counts edges from the cycle-0 edge until pll_resetb first rises and
  // until ready rises. drop_c != 0 holds pll_lock low for that one edge.
  task automatic measure_bringup(input string tag, input int drop_c,
                                 input int exp_rise, input int exp_ready);
    int rise_c;
    int ready_c;
    rise_c  = -1;
    ready_c = -1;
    for (int c = 1; c <= 80; c++) begin
      pll_lock = (c != drop_c);
      tick();
      if (pll_resetb && rise_c < 0) rise_c = c;
      if (ready) begin
        ready_c = c;
        break;
      end
    end
    pll_lock = 1'b1;
    check({tag, "_resetb_rise"}, rise_c, exp_rise);
    check({tag, "_ready_cycle"}, ready_c, exp_ready);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fault_c;
    int lat;
    int lvl_left;

    m_hist     = '{1'b0, 1'b0};
    reset      = 1'b1;
    pll_lock   = 1'b1;
    relock_req = 1'b0;

    // Normal bring-up with lock present from the start.
    apply_reset();
    check("reset_ready_low", ready, 0);
    measure_bringup("bringup", 0, 4, 13);

    // A relock from RUN, with a one-cycle lock glitch while STABLE is at count 5.
    pulse_relock();
    check("relock_sys_reset", sys_reset, 1);
    measure_bringup("stable_glitch", 9, 4, 20);

    // Repeated lock loss in RUN. Each loss raises sys_reset after three edges.
    for (int i = 0; i < 300; i++) begin
      lat = -1;
      pll_lock = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        tick();
        if (sys_reset) begin
          lat = c;
          break;
        end
      end
      check("loss_latency", lat, 3);
      pll_lock = 1'b1;
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
        tick();
        if (ready) begin
          lat = c;
          break;
        end
      end
      check("loss_recover", (lat > 0), 1);
    end
`ifdef PLL_SEQ_STATUS_EN
    check("loss_saturated", lock_loss_count, 255);
`endif

    // With no lock at all, two retries run and then the block latches FAULT.
    pll_lock = 1'b0;
    apply_reset();
    fault_c = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (fault) begin
        fault_c = c;
        break;
      end
    end
    check("fault_cycle", fault_c, 3 * (RESET_CYCLES + LOCK_TIMEOUT));
    check("fault_resetb", pll_resetb, 0);
    repeat (100) tick();
    check("fault_held", fault, 1);

    // A relock from FAULT brings the block back to RUN.
    pll_lock = 1'b1;
    pulse_relock();
    check("fault_exit", fault, 0);
`ifdef PLL_SEQ_STATUS_EN
    check("fault_exit_retries", retry_count, 0);
`endif
    measure_bringup("fault_relock", 0, 4, 13);

    // Assert reset in the middle of WAIT, when the count is 10.
    pll_lock = 1'b0;
    apply_reset();
    repeat (RESET_CYCLES + 10) tick();
    check("midwait_resetb", pll_resetb, 1);
    reset = 1'b1;
    tick();
    check("midwait_rst_resetb", pll_resetb, 0);
    check("midwait_rst_sys_reset", sys_reset, 1);
    check("midwait_rst_ready", ready, 0);
    check("midwait_rst_fault", fault, 0);
    reset = 1'b0;
    measure_bringup("after_reset", 0, 4, 13);

    // Randomized lock levels, relock pulses and occasional resets.
    lvl_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (lvl_left == 0) begin
        pll_lock = 1'($urandom_range(0, 1));
        lvl_left = $urandom_range(1, 60);
      end
      lvl_left--;
      relock_req = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset      = 1'b0;
    relock_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
